// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// alu_sequencer : decodes 16-bit instructions, drives the ALU, writes back r0-r15
// Optional flags: define ALU_SEQUENCER_FLAGS_EN     Revision: 1.0
// ============================================================================
module alu_sequencer #(
  parameter int NUM_REGS  = 16,
  parameter int MAX_SHIFT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] instr_in,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [3:0]  alu_instruction,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_result,
  output logic        done,
  output logic [15:0] result,
  output logic        illegal,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic        zero_flag,
  output logic        neg_flag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    K_ALU     = 2'd0,
    K_BYPASS  = 2'd1,
    K_MOVI    = 2'd2,
    K_ILLEGAL = 2'd3
  } kind_e;

  localparam logic [3:0]  OP_ADD      = 4'd5;
  localparam logic [15:0] C_MAX_SHIFT = 16'(MAX_SHIFT);

  state_e      state_q, state_d;
  kind_e       kind_q, kind_d;
  logic [15:0] instr_q;
  logic [15:0] regs_q [NUM_REGS];
  logic [15:0] opa_q;
  logic [3:0]  alu_op_q, alu_op_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [15:0] result_q;
  logic [15:0] wb_val;

  logic [3:0]  op, rd, rs, rt;
  logic [15:0] opa, opb;

  assign op  = instr_q[15:12];
  assign rd  = instr_q[11:8];
  assign rs  = instr_q[7:4];
  assign rt  = instr_q[3:0];
  assign opa = regs_q[rs];
  assign opb = regs_q[rt];

  assign alu_instruction = alu_op_q;
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign result          = result_q;
  assign dbg_data        = regs_q[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = S_READ;
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: state_d = S_WB;
      S_WB: begin
        done    = 1'b1;
        illegal = (kind_q == K_ILLEGAL);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Decode in READ; MOVI and illegal ops leave the ALU drive registers untouched.
  always_comb begin
    kind_d   = K_ALU;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    case (op)
      4'd0, 4'd1, 4'd2, 4'd5, 4'd6: begin
        alu_op_d = op;
        alu_a_d  = opa;
        alu_b_d  = opb;
      end
      4'd3, 4'd4: begin
        alu_op_d = op;
        alu_a_d  = opa;
        if (opb == 16'd0) begin
          alu_b_d = 16'd1;
          kind_d  = K_BYPASS;
        end else if (opb > C_MAX_SHIFT) begin
          alu_b_d = C_MAX_SHIFT;
        end else begin
          alu_b_d = opb;
        end
      end
      4'd7: begin
        alu_op_d = OP_ADD;
        alu_a_d  = opa;
        alu_b_d  = {12'd0, rt};
      end
      4'd8:    kind_d = K_MOVI;
      default: kind_d = K_ILLEGAL;
    endcase
  end

  always_comb begin
    wb_val = 16'd0;
    case (kind_q)
      K_ALU:    wb_val = alu_result;
      K_BYPASS: wb_val = opa_q;
      K_MOVI:   wb_val = {8'd0, instr_q[7:0]};
      default:  wb_val = 16'd0;
    endcase
  end

  // Write-back lands on the EXEC->WB edge so done, result and the register agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q  <= 16'd0;
      kind_q   <= K_ALU;
      opa_q    <= 16'd0;
      alu_op_q <= 4'd0;
      alu_a_q  <= 16'd0;
      alu_b_q  <= 16'd0;
      result_q <= 16'd0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 16'd0;
    end else begin
      if (state_q == S_IDLE && instr_valid) instr_q <= instr_in;
      if (state_q == S_READ) begin
        kind_q   <= kind_d;
        opa_q    <= opa;
        alu_op_q <= alu_op_d;
        alu_a_q  <= alu_a_d;
        alu_b_q  <= alu_b_d;
      end
      if (state_q == S_EXEC) begin
        result_q <= wb_val;
        if (kind_q != K_ILLEGAL) regs_q[rd] <= wb_val;
      end
    end
  end

`ifdef ALU_SEQUENCER_FLAGS_EN
  logic zero_q, neg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (state_q == S_EXEC && kind_q != K_ILLEGAL) begin
      zero_q <= (wb_val == 16'd0);
      neg_q  <= wb_val[15];
    end
  end

  assign zero_flag = zero_q;
  assign neg_flag  = neg_q;
`else
  assign zero_flag = 1'b0;
  assign neg_flag  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// tb_alu_sequencer : directed scoreboard bench for alu_sequencer   Revision: 1.0
// ============================================================================
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  alu_instruction;
  logic [15:0] alu_a, alu_b, alu_result;
  logic        done;
  logic [15:0] result;
  logic        illegal;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        zero_flag, neg_flag;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset),
    .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .alu_instruction(alu_instruction), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .done(done), .result(result), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .zero_flag(zero_flag), .neg_flag(neg_flag)
  );

  // Combinational ALU the sequencer drives.
  always_comb begin
    case (alu_instruction)
      4'd0:    alu_result = ~alu_a;
      4'd1:    alu_result = alu_a & alu_b;
      4'd2:    alu_result = alu_a | alu_b;
      4'd3:    alu_result = alu_a >> alu_b;
      4'd4:    alu_result = alu_a << alu_b;
      4'd5:    alu_result = alu_a + alu_b;
      4'd6:    alu_result = alu_a - alu_b;
      default: alu_result = 16'h0000;
    endcase
  end

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  logic [18:0] exp_q[$];
  logic [18:0] mon_e;
  logic [15:0] m_regs [16];
  logic        m_zf, m_nf;
  logic [3:0]  ex_op;
  logic [15:0] ex_a, ex_b;
  int          hs, last_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: updates the shadow register file and queues {nf,zf,ill,result}.
  task automatic model_push(input logic [15:0] ins);
    logic [3:0]  op, rd, rs, rt;
    logic [15:0] a, b, r;
    logic        ill;
    op = ins[15:12]; rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    a = m_regs[rs]; b = m_regs[rt]; r = 16'h0000; ill = 1'b0;
    case (op)
      4'd0: r = ~a;
      4'd1: r = a & b;
      4'd2: r = a | b;
      4'd3: r = (b == 16'd0) ? a : ((b >= 16'd16) ? 16'h0000 : (a >> b));
      4'd4: r = (b == 16'd0) ? a : ((b >= 16'd16) ? 16'h0000 : (a << b));
      4'd5: r = a + b;
      4'd6: r = a - b;
      4'd7: r = a + {12'h000, rt};
      4'd8: r = {8'h00, ins[7:0]};
      default: ill = 1'b1;
    endcase
    if (!ill) begin
      m_regs[rd] = r;
      m_zf = (r == 16'h0000);
      m_nf = r[15];
    end
    exp_q.push_back({m_nf, m_zf, ill, r});
  endtask

  // Issue one instruction and check the N+3 retirement timing; captures EXEC drive.
  task automatic issue(input logic [15:0] ins);
    @(negedge clk);
    chk("ready_before_issue", 32'(instr_ready), 32'd1);
    instr_in    = ins;
    instr_valid = 1'b1;
    model_push(ins);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) begin
        instr_valid = 1'b0;
        instr_in    = 16'($urandom);
      end
      chk("busy_ready", 32'(instr_ready), 32'd0);
      chk("done_latency", 32'(done), 32'(k == 3));
      if (k == 2) begin
        ex_op = alu_instruction;
        ex_a  = alu_a;
        ex_b  = alu_b;
      end
    end
  endtask

  task automatic chk_reg(input logic [3:0] a, input logic [15:0] e);
    dbg_addr = a;
    #1;
    chk($sformatf("reg%0d", a), 32'(dbg_data), 32'(e));
  endtask

  // Scoreboard: every done pops one expected retirement.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wb_result", 32'(result), 32'(mon_e[15:0]));
        chk("wb_illegal", 32'(illegal), 32'(mon_e[16]));
`ifdef ALU_SEQUENCER_FLAGS_EN
        chk("zero_flag", 32'(zero_flag), 32'(mon_e[17]));
        chk("neg_flag", 32'(neg_flag), 32'(mon_e[18]));
`else
        chk("zero_flag_tied", 32'(zero_flag), 32'd0);
        chk("neg_flag_tied", 32'(neg_flag), 32'd0);
`endif
      end
    end else if (illegal) begin
      chk("illegal_without_done", 32'(illegal), 32'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_zf = 1'b0; m_nf = 1'b0;
    reset = 1'b1; instr_in = 16'h0000; instr_valid = 1'b0; dbg_addr = 4'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_alu_op", 32'(alu_instruction), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_alu_b", 32'(alu_b), 32'd0);
    chk("rst_zero_flag", 32'(zero_flag), 32'd0);
    chk("rst_neg_flag", 32'(neg_flag), 32'd0);
    for (int i = 0; i < 16; i++) chk_reg(4'(i), 16'h0000);

    issue(16'h8134);  chk_reg(4'd1, 16'h0034);
    chk("movi_result", 32'(result), 32'h0034);
    issue(16'h822F);
    issue(16'h0220);  chk_reg(4'd2, 16'hFFD0);
    chk("not_exec_op", 32'(ex_op), 32'd0);
    chk("not_exec_a", 32'(ex_a), 32'h002F);
    issue(16'h5312);  chk_reg(4'd3, 16'h0004);
    issue(16'h8101);
    issue(16'h6401);  chk_reg(4'd4, 16'hFFFF);
`ifdef ALU_SEQUENCER_FLAGS_EN
    chk("sub_neg_flag", 32'(neg_flag), 32'd1);
    chk("sub_zero_flag", 32'(zero_flag), 32'd0);
`endif

    issue(16'h8780);
    issue(16'h8808);
    issue(16'h4778);  chk_reg(4'd7, 16'h8000);
    issue(16'h5471);  chk_reg(4'd4, 16'h8001);
    issue(16'h8500);
    chk("movi_holds_op", 32'(ex_op), 32'd5);
    chk("movi_holds_a", 32'(ex_a), 32'h8000);
    chk("movi_holds_b", 32'(ex_b), 32'h0001);
    issue(16'h4645);  chk_reg(4'd6, 16'h8001);
    chk("bypass_alu_b", 32'(ex_b), 32'h0001);
    chk("bypass_alu_op", 32'(ex_op), 32'd4);
    issue(16'h8514);
    issue(16'h4645);  chk_reg(4'd6, 16'h0000);
    chk("clamp_alu_b", 32'(ex_b), 32'd16);
    issue(16'h8501);
    issue(16'h3645);  chk_reg(4'd6, 16'h4000);
    chk("shr_alu_b", 32'(ex_b), 32'h0001);
    issue(16'h1634);  chk_reg(4'd6, 16'h0000);
    issue(16'h2634);  chk_reg(4'd6, 16'h8005);
    issue(16'h7A4F);  chk_reg(4'd10, 16'h8010);
    chk("addi_alu_b", 32'(ex_b), 32'h000F);
    issue(16'hF123);  chk_reg(4'd1, 16'h0001);
    chk("illegal_result", 32'(result), 32'd0);
    issue(16'h9ABC);
    for (int i = 0; i < 16; i++) chk_reg(4'(i), m_regs[i]);

    // Back-to-back ADDI stream with valid held high.
    @(negedge clk);
    instr_in = 16'h7111; instr_valid = 1'b1; hs = 0; last_c = 0;
    for (int c = 0; c < 16; c++) begin
      if (instr_ready) begin
        model_push(16'h7111);
        if (hs > 0) chk("issue_interval", 32'(c - last_c), 32'd4);
        last_c = c;
        hs++;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("stream_handshakes", 32'(hs), 32'd4);
    chk_reg(4'd1, 16'h0005);

    // Reset while the instruction sits in EXEC.
    @(negedge clk);
    instr_in = 16'h8955; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_no_done", 32'(done), 32'd0);
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_zf = 1'b0; m_nf = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(instr_ready), 32'd1);
    chk("abort_done_low", 32'(done), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk_reg(4'd9, 16'h0000);
    chk_reg(4'd1, 16'h0000);

    issue(16'h8134);  chk_reg(4'd1, 16'h0034);
    @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Issuing end of the 16-bit ALU interface.
- Accepts 16-bit instruction words over a valid/ready handshake and decodes them.
- Reads operands from an internal 16x16 register file, drives the ALU's opcode/A/B inputs, samples the ALU result and writes it back.
- Sits between the instruction source (fetch/testbench) and the combinational ALU.

Parameters:
- NUM_REGS, 16, register file depth; fixed at 16 (4-bit register fields).
- MAX_SHIFT, 16, largest shift amount the ALU accepts; larger amounts are clamped to this.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- instr_in  in  16  instruction word: [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt.
- instr_valid  in  1  instr_in valid.
- instr_ready  out  1  block can accept an instruction.
- alu_instruction  out  4  ALU opcode: NOT=0, AND=1, OR=2, SHIFTR=3, SHIFTL=4, ADD=5, SUB=6.
- alu_a  out  16  ALU operand A.
- alu_b  out  16  ALU operand B.
- alu_result  in  16  ALU data_out, combinational from alu_* ports.
- done  out  1  one-cycle pulse; instruction retired.
- result  out  16  value written back (or 0 for illegal); held until the next done.
- illegal  out  1  one-cycle pulse with done when op is unsupported.
- dbg_addr  in  4  debug register select.
- dbg_data  out  16  combinational read of reg[dbg_addr].

Behaviour:
- Reset state: one clock; synchronous active-high reset. On reset, all regs=0, FSM=IDLE, instr_ready=1, done=0, illegal=0, result=0, alu_instruction=0, alu_a=0, alu_b=0.
- FSM states: IDLE -> READ -> EXEC -> WB -> IDLE.
- instr_ready=1 only in IDLE. A handshake (valid & ready) latches instr_in and moves to READ. The source must hold instr_in stable only during the handshake cycle.
- READ: opA=reg[rs], opB=reg[rt]; decoded opcode registered.
- EXEC: alu_* ports driven from registered values; alu_result sampled at the end of EXEC.
- WB: reg[rd] written, result updated, done=1 for this cycle only. Next cycle is IDLE with instr_ready=1.
- Timing: handshake at cycle N gives done at N+3. Minimum issue interval is 4 cycles.
- Ops 0-6 (ALU ops): alu_instruction=op, alu_a=opA, alu_b=opB. NOT ignores rt.
- Shift amounts (ops 3/4):
  - opB==0: alu_b=1, but the result bypasses the ALU and result=opA.
  - opB>MAX_SHIFT: alu_b=MAX_SHIFT (result 0).
  - Otherwise alu_b=opB.
- Op 7 ADDI: alu_instruction=ADD, alu_b={12'b0, rt}.
- Op 8 MOVI: result={8'b0, instr[7:0]}; ALU not used; alu_* ports hold their previous values.
- Ops 9-15: no register write, result=0, done=1 and illegal=1 in WB.
- Width: all arithmetic is 16-bit modulo 2^16; carry/borrow are discarded.
- alu_* outputs hold their values outside EXEC; the ALU is only sampled in EXEC.
- rd==rs/rt is allowed. The next instruction always sees the written value, since WB completes before IDLE.
- Reset in any state aborts the instruction: no writeback, no done, registers cleared.
- instr_valid while not ready is ignored; nothing is queued.

Optional Feature:
- Macro ALU_SEQUENCER_FLAGS_EN.
- Defined: adds outputs zero_flag and neg_flag (1 bit each).
  - Registered in WB of ALU ops 0-7 and MOVI: zero_flag=(result==0), neg_flag=result[15].
  - Unchanged on illegal ops; reset to 0.
- Undefined: the ports are still present but tied to 0, and no flag logic is built.

Test Plan:
- Reset held 2 cycles -> instr_ready=1, done=0, dbg_data=0 for all 16 dbg_addr values.
- MOVI 16'h8134 handshake at cycle N -> done=1 at N+3 only, result=16'h0034, reg1=16'h0034, instr_ready=0 during N+1..N+3.
- reg1=16'h0034, reg2=16'hFFD0; ADD 16'h5312 -> reg3=16'h0004. Then SUB 16'h6401 with reg0=0, reg1=1 -> reg4=16'hFFFF; with the macro, neg_flag=1 and zero_flag=0.
- Shifts, reg4=16'h8001:
  - reg5=0, SHIFTL 16'h4645 -> reg6=16'h8001 (bypass).
  - reg5=20 -> alu_b=16 in EXEC, result=0.
  - reg5=1, SHIFTR 16'h3645 -> reg6=16'h4000.
- Illegal 16'hF123 -> done=1 and illegal=1 in the same cycle, result=0, reg1 unchanged.
- instr_valid held high with a stream of ADDI instructions -> one handshake every 4 cycles. Reset asserted in EXEC -> no done, reg[rd]=0, instr_ready=1 the cycle after reset deasserts.
